// File: rtl/align_shiftright_if.sv
// Handshake and data bundle for the mantissa right-align unit.
// Operands come in on the input side; the aligned pair leaves on the output side.
interface align_shiftright_if #(
  parameter int MW = 24,
  parameter int EW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] exp_a;
  logic [MW-1:0] mant_a;
  logic [EW-1:0] exp_b;
  logic [MW-1:0] mant_b;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] exp_out;
  logic [MW-1:0] mant_big;
  logic [MW+2:0] mant_small;
  logic          swapped;

  modport master (
    output in_valid, exp_a, mant_a, exp_b, mant_b, out_ready,
    input  in_ready, out_valid, exp_out, mant_big, mant_small, swapped
  );

  modport slave (
    input  in_valid, exp_a, mant_a, exp_b, mant_b, out_ready,
    output in_ready, out_valid, exp_out, mant_big, mant_small, swapped
  );
endinterface

// File: rtl/align_shiftright.sv
// Two-stage mantissa alignment: S1 picks the larger exponent and clamps the shift,
// S2 right-shifts the smaller mantissa with a log shifter collapsing lost bits into sticky.
module align_shiftright #(
  parameter int MW = 24,
  parameter int EW = 8
) (
  input logic             clk,
  input logic             rst_n,
  align_shiftright_if.slave bus
);
  localparam int XW  = MW + 3;
  localparam int SHW = $clog2(XW + 1);

  logic          s1_valid;
  logic [EW-1:0] s1_exp;
  logic [MW-1:0] s1_big;
  logic [MW-1:0] s1_small;
  logic [SHW-1:0] s1_sh;
  logic          s1_swap;

  logic          s2_valid;
  logic [EW-1:0] s2_exp;
  logic [MW-1:0] s2_big;
  logic [XW-1:0] s2_small;
  logic          s2_swap;

  logic          s2_load;
  logic          in_rdy;

  logic          b_larger;
  logic [EW-1:0] diff;
  logic [SHW-1:0] sh_clamp;

  logic [XW-1:0] sh_vec;
  logic [XW-1:0] drop_mask;
  logic          sticky;
  logic [XW-1:0] aligned;

  assign s2_load = !s2_valid || bus.out_ready;
  assign in_rdy  = !s1_valid || s2_load;

  // Ties keep A as the big operand, so only a strictly larger B swaps.
  always_comb begin
    b_larger = bus.exp_b > bus.exp_a;
    diff     = b_larger ? (bus.exp_b - bus.exp_a) : (bus.exp_a - bus.exp_b);
    sh_clamp = (int'(diff) >= XW) ? SHW'(XW) : SHW'(diff);
  end

  // Each power-of-two stage ORs the bits it drops into a running sticky.
  always_comb begin
    sh_vec    = {s1_small, 3'b000};
    drop_mask = '0;
    sticky    = 1'b0;
    for (int i = SHW - 1; i >= 0; i--) begin
      if (s1_sh[i]) begin
        drop_mask = (XW'(1) << (2 ** i)) - XW'(1);
        sticky    = sticky | (|(sh_vec & drop_mask));
        sh_vec    = sh_vec >> (2 ** i);
      end
    end
    if (int'(s1_sh) >= XW) begin
      aligned = {{(XW-1){1'b0}}, |s1_small};
    end else begin
      aligned = {sh_vec[XW-1:1], sh_vec[0] | sticky};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_exp   <= '0;
      s1_big   <= '0;
      s1_small <= '0;
      s1_sh    <= '0;
      s1_swap  <= 1'b0;
      s2_valid <= 1'b0;
      s2_exp   <= '0;
      s2_big   <= '0;
      s2_small <= '0;
      s2_swap  <= 1'b0;
    end else begin
      if (in_rdy) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_exp   <= b_larger ? bus.exp_b  : bus.exp_a;
          s1_big   <= b_larger ? bus.mant_b : bus.mant_a;
          s1_small <= b_larger ? bus.mant_a : bus.mant_b;
          s1_sh    <= sh_clamp;
          s1_swap  <= b_larger;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_exp   <= s1_exp;
          s2_big   <= s1_big;
          s2_small <= aligned;
          s2_swap  <= s1_swap;
        end
      end
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = s2_valid;
  assign bus.exp_out    = s2_exp;
  assign bus.mant_big   = s2_big;
  assign bus.mant_small = s2_small;
  assign bus.swapped    = s2_swap;
endmodule

// File: tb/tb_align_shiftright.sv
// Bench for align_shiftright: literal directed vectors plus an arithmetic reference
// model with an in-order expectation queue checked every cycle.
module tb_align_shiftright;
  localparam int MW = 24;
  localparam int EW = 8;
  localparam int XW = MW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  align_shiftright_if #(.MW(MW), .EW(EW)) bus();
  align_shiftright #(.MW(MW), .EW(EW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [EW-1:0] e;
    logic [MW-1:0] mb;
    logic [XW-1:0] ms;
    logic          sw;
  } res_t;

  res_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int n_emit = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [EW-1:0] ea, input logic [MW-1:0] ma,
                                 input logic [EW-1:0] eb, input logic [MW-1:0] mb);
    res_t r;
    int d;
    logic [MW-1:0] sm;
    logic [63:0] x, y, lost;
    r.sw = eb > ea;
    r.e  = r.sw ? eb : ea;
    r.mb = r.sw ? mb : ma;
    sm   = r.sw ? ma : mb;
    d    = r.sw ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
    if (d >= XW) begin
      r.ms = XW'(sm != 0);
    end else begin
      x    = 64'(sm) << 3;
      y    = x >> d;
      lost = x & ((64'd1 << d) - 64'd1);
      r.ms = y[XW-1:0];
      r.ms[0] = r.ms[0] | (lost != 0);
    end
    return r;
  endfunction

  // Checks every cycle: in_ready from occupancy, outputs against the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      logic acc;
      acc = bus.in_valid && bus.in_ready;
      chk("in_ready", 64'(bus.in_ready), 64'((q.size() < 2) || bus.out_ready));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("stray_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          chk("exp_out", 64'(bus.exp_out), 64'(q[0].e));
          chk("mant_big", 64'(bus.mant_big), 64'(q[0].mb));
          chk("mant_small", 64'(bus.mant_small), 64'(q[0].ms));
          chk("swapped", 64'(bus.swapped), 64'(q[0].sw));
          if (bus.out_ready) begin
            void'(q.pop_front());
            n_emit++;
          end
        end
      end
      if (acc) q.push_back(model(bus.exp_a, bus.mant_a, bus.exp_b, bus.mant_b));
    end
  end

  task automatic send(input logic [EW-1:0] ea, input logic [MW-1:0] ma,
                      input logic [EW-1:0] eb, input logic [MW-1:0] mb);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.exp_a = ea;
    bus.mant_a = ma;
    bus.exp_b = eb;
    bus.mant_b = mb;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'(ok), 64'd1);
  endtask

  // Single pair into an empty pipe with out_ready high; result must appear two edges later.
  task automatic lit(input string name, input logic [EW-1:0] ea, input logic [MW-1:0] ma,
                     input logic [EW-1:0] eb, input logic [MW-1:0] mb,
                     input logic [EW-1:0] ee, input logic [MW-1:0] emb,
                     input logic [XW-1:0] ems, input logic esw);
    send(ea, ma, eb, mb);
    chk({name, "_early"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_exp"}, 64'(bus.exp_out), 64'(ee));
    chk({name, "_big"}, 64'(bus.mant_big), 64'(emb));
    chk({name, "_small"}, 64'(bus.mant_small), 64'(ems));
    chk({name, "_swap"}, 64'(bus.swapped), 64'(esw));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [EW-1:0] ea, eb;
    bus.in_valid = 1'b0;
    bus.exp_a = '0;
    bus.mant_a = '0;
    bus.exp_b = '0;
    bus.mant_b = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mant_small", 64'(bus.mant_small), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    lit("basic", 8'd130, 24'hC00000, 8'd127, 24'h800000, 8'd130, 24'hC00000, 27'h0800000, 1'b0);
    drain("drain_basic");
    lit("swap", 8'd100, 24'h800001, 8'd104, 24'hFFFFFF, 8'd104, 24'hFFFFFF, 27'h0400001, 1'b1);
    drain("drain_swap");
    lit("tie", 8'd127, 24'h123456, 8'd127, 24'hABCDEF, 8'd127, 24'h123456, 27'h55E6F78, 1'b0);
    drain("drain_tie");
    lit("far", 8'd200, 24'hFFFFFF, 8'd100, 24'h800000, 8'd200, 24'hFFFFFF, 27'h0000001, 1'b0);
    drain("drain_far");
    lit("d24", 8'd124, 24'h400000, 8'd100, 24'h800001, 8'd124, 24'h400000, 27'h0000005, 1'b0);
    drain("drain_d24");

    // Shift sweep, alternating which operand is larger, streamed back to back.
    for (int d = 0; d <= 30; d++) begin
      ea = (d % 2 == 0) ? 8'(60 + d) : 8'd60;
      eb = (d % 2 == 0) ? 8'd60 : 8'(60 + d);
      send(ea, 24'($urandom), eb, 24'($urandom));
    end
    drain("drain_sweep");

    base = n_emit;
    fork
      begin
        for (int k = 0; k < 5; k++) send(8'($urandom_range(90, 140)), 24'($urandom),
                                         8'($urandom_range(90, 140)), 24'($urandom));
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    chk("bp_count", 64'(n_emit - base), 64'd5);

    bus.out_ready = 1'b0;
    send(8'd10, 24'h111111, 8'd12, 24'h222222);
    send(8'd50, 24'h333333, 8'd40, 24'h444444);
    chk("full_before_rst", 64'(bus.out_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_exp_out", 64'(bus.exp_out), 64'd0);
    chk("midrst_mant_big", 64'(bus.mant_big), 64'd0);
    chk("midrst_mant_small", 64'(bus.mant_small), 64'd0);
    chk("midrst_swapped", 64'(bus.swapped), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rel_out_valid", 64'(bus.out_valid), 64'd0);
    lit("after_rst", 8'd90, 24'hF00000, 8'd91, 24'h800000, 8'd91, 24'h800000, 27'h3C00000, 1'b1);
    drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
